// File: rtl/rsa_pkg.sv
// Shared RSA constants and FSM state encoding, used by both the
// decrypt and encrypt datapaths.
package rsa_pkg;

    localparam int N      = 3233;
    localparam int E      = 17;
    localparam int D      = 2753;
    localparam int D_BITS = 12;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int PT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        MUL,
        SQR
    } state_e;

endpackage

// File: rtl/rsa_decryptor_if.sv
// Request/response bundle between an RSA decrypt client and the decryptor.
interface rsa_decryptor_if;

    logic        start;
    logic [15:0] ciphertext;
    logic        busy;
    logic        done;
    logic [7:0]  plaintext;
    logic        range_err;

    modport master (
        output start, ciphertext,
        input  busy, done, plaintext, range_err
    );

    modport slave (
        input  start, ciphertext,
        output busy, done, plaintext, range_err
    );

endinterface

// File: rtl/rsa_modmul.sv
// Combinational (a*b) mod N; the full product is kept before reduction.
module rsa_modmul #(
    parameter int N = rsa_pkg::N
) (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] r_o
);
    import rsa_pkg::*;

    logic [PROD_W-1:0] prod;

    assign prod = PROD_W'(a_i) * PROD_W'(b_i);
    assign r_o  = OP_W'(prod % PROD_W'(N));

endmodule

// File: rtl/rsa_decryptor.sv
// RSA decryptor: ciphertext^D mod N by right-to-left square-and-multiply,
// one shared modular multiplier stepped by a small FSM.
module rsa_decryptor #(
    parameter int N      = rsa_pkg::N,
    parameter int D      = rsa_pkg::D,
    parameter int D_BITS = rsa_pkg::D_BITS
) (
    input  logic          clk,
    input  logic          reset,
    rsa_decryptor_if.slave bus
);
    import rsa_pkg::*;

    state_e            state_q;
    logic [OP_W-1:0]   ct_q;
    logic [OP_W-1:0]   base_q;
    logic [OP_W-1:0]   result_q;
    logic [D_BITS-1:0] exp_q;
    logic [D_BITS-1:0] exp_d;
    logic              busy_q;
    logic              done_q;
    logic [PT_W-1:0]   pt_q;
    logic              err_q;

    logic [OP_W-1:0]   mm_a;
    logic [OP_W-1:0]   mm_b;
    logic [OP_W-1:0]   mm_r;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mm_a = base_q;
        mm_b = base_q;
        unique case (state_q)
            REDUCE: begin
                mm_a = ct_q;
                mm_b = OP_W'(1);
            end
            MUL: begin
                mm_a = result_q;
                mm_b = base_q;
            end
            default: ;
        endcase
    end

    assign exp_d = exp_q >> 1;

    rsa_modmul #(.N(N)) u_modmul (
        .a_i (mm_a),
        .b_i (mm_b),
        .r_o (mm_r)
    );

    // NOTE: all state uses non-blocking assignments so every register sees
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pt_q     <= '0;
            err_q    <= 1'b0;
            result_q <= OP_W'(1);
            base_q   <= '0;
            exp_q    <= '0;
            ct_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        ct_q     <= bus.ciphertext;
                        result_q <= OP_W'(1);
                        exp_q    <= D_BITS'(D);
                        state_q  <= REDUCE;
                        busy_q   <= 1'b1;
                    end
                end
                REDUCE: begin
                    base_q  <= mm_r;
                    state_q <= MUL;
                end
                MUL: begin
                    if (exp_q[0]) begin
                        result_q <= mm_r;
                    end
                    state_q <= SQR;
                end
                SQR: begin
                    base_q <= mm_r;
                    exp_q  <= exp_d;
                    if (exp_d != '0) begin
                        state_q <= MUL;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pt_q    <= result_q[PT_W-1:0];
                        err_q   <= (result_q > OP_W'(255));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.plaintext = pt_q;
    assign bus.range_err = err_q;

endmodule

// File: tb/tb_rsa_decryptor.sv
// Scoreboard bench for rsa_decryptor: a plain-arithmetic modular power model
// predicts each result; a monitor checks every done pulse against the queue.
module tb_rsa_decryptor;

    localparam int MOD     = 3233;
    localparam int PUB     = 17;
    localparam int PRIV    = 2753;
    localparam int LATENCY = 26;

    typedef struct {
        int pt;
        int err;
        int acc;
    } expect_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    expect_t sb[$];

    rsa_decryptor_if bus ();

    rsa_decryptor #(
        .N      (MOD),
        .D      (PRIV),
        .D_BITS (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Power by repeated multiplication: deliberately not square-and-multiply.
    function automatic int modpow(input int b, input int e, input int n);
        int r;
        int bb;
        r  = 1 % n;
        bb = b % n;
        for (int i = 0; i < e; i++) r = (r * bb) % n;
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a request at the current negedge; it is accepted on the next posedge.
    task automatic issue(input int ct);
        int m;
        m = modpow(ct, PRIV, MOD);
        bus.start      = 1'b1;
        bus.ciphertext = 16'(ct);
        sb.push_back('{m % 256, (m > 255) ? 1 : 0, cyc + 1});
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("done_within_bound", seen, 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    check("plaintext", bus.plaintext, e.pt);
                    check("range_err", bus.range_err, e.err);
                    check("latency", cyc + 1 - e.acc, LATENCY);
                    check("busy_at_done", bus.busy, 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        checks = 0;
        errors = 0;

        // Reset held while start is also high: reset must win.
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.ciphertext = 16'd2790;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_plaintext", bus.plaintext, 0);
        check("reset_range_err", bus.range_err, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_without_start", bus.busy, 0);

        // Reference vector, then small and reduced edge cases back-to-back.
        issue(2790);
        wait_done(); issue(0);
        wait_done(); issue(1);
        wait_done(); issue(3234);
        wait_done(); issue(modpow(1000, PUB, MOD));

        // Full byte round trip, every start issued in the previous done cycle.
        for (int m = 0; m < 256; m++) begin
            wait_done();
            issue(modpow(m, PUB, MOD));
        end

        // Random 16-bit ciphertexts, including values >= N.
        for (int k = 0; k < 30; k++) begin
            wait_done();
            issue(int'($urandom_range(0, 65535)));
        end
        wait_done();

        // start re-pulsed mid-job must be ignored.
        repeat (2) @(negedge clk);
        acc = cyc + 1;
        issue(2790);
        while (cyc < acc + 9) @(negedge clk);
        bus.start      = 1'b1;
        bus.ciphertext = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (30) @(negedge clk);

        // Reset mid-job abandons it; a start right after reset is accepted.
        acc = cyc + 1;
        issue(2790);
        while (cyc < acc + 11) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_plaintext", bus.plaintext, 0);
        check("abort_range_err", bus.range_err, 0);
        reset = 1'b0;
        issue(2790);
        wait_done();
        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_decryptor.md
RSA_DECRYPTOR -- requirements
Module: rsa_decryptor

Interface
REQ-001 The block SHALL have parameter N, default 3233, meaning the RSA modulus.
REQ-002 The block SHALL have parameter D, default 2753, meaning the private exponent.
REQ-003 The block SHALL have parameter D_BITS, default 12, meaning the number of exponent bits processed, MSB of D at bit D_BITS-1.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, a request to decrypt ciphertext; sampled only in IDLE.
REQ-007 The block SHALL have port ciphertext, input, 16 bits, the value captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit, high from the cycle after acceptance until done.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when plaintext is updated.
REQ-010 The block SHALL have port plaintext, output, 8 bits, the decrypted byte, held until the next done.
REQ-011 The block SHALL have port range_err, output, 1 bit, set with done when the full result is >= 256; held until the next done.

Function
REQ-012 The block SHALL compute ciphertext^D mod N by right-to-left square-and-multiply over D_BITS exponent bits.
REQ-013 The FSM SHALL use states IDLE, REDUCE, MUL, SQR.
REQ-014 IDLE with start=1 SHALL latch ciphertext, load result=1 and exp=D, and go to REDUCE.
REQ-015 IDLE with start=0 SHALL stay in IDLE.
REQ-016 REDUCE SHALL perform base <= ciphertext mod N (1 cycle) and then go to MUL.
REQ-017 MUL SHALL perform result <= (result*base) mod N if exp[0]=1, else hold result, and then go to SQR.
REQ-018 SQR SHALL perform base <= (base*base) mod N and exp <= exp>>1.
REQ-019 SQR SHALL go to MUL if the shifted exp is nonzero, else return to IDLE and assert done.
REQ-020 Products SHALL be formed at 32-bit width, and operands and residues SHALL be stored at 16 bits; no truncation before the reduction.
REQ-021 With default parameters, done SHALL be high exactly 26 cycles after the edge that accepted start (1 REDUCE cycle + 12 x (MUL+SQR) cycles, plus the done cycle boundary).
REQ-022 On the completing edge, the block SHALL set plaintext <= result[7:0] and range_err <= (result > 255).
REQ-023 start while busy SHALL be ignored, with no restart and no queuing.
REQ-024 start asserted in the done cycle SHALL be accepted (FSM already IDLE), giving back-to-back operation.
REQ-025 ciphertext >= N SHALL be legal and SHALL be reduced in REDUCE.
REQ-026 ciphertext mod N = 0 SHALL yield plaintext 0.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 While reset=1 at an edge, the block SHALL set state=IDLE, busy=0, done=0, plaintext=0, range_err=0, result=1, base=0, exp=0.
REQ-029 Reset during an operation SHALL abandon it without a done pulse; the block SHALL accept start on the first edge after reset deasserts.
REQ-030 reset SHALL take priority over start on the same edge.

Structure
REQ-031 Package rsa_pkg SHALL hold N=3233, E=17, D=2753, D_BITS=12 and the FSM state enum, shared with the encrypt datapath.
REQ-032 The block SHALL contain one sub-module, rsa_modmul, a combinational (a*b) mod N with 16-bit inputs, 32-bit internal product and 16-bit output; it SHALL be instantiated once and shared by MUL, SQR and REDUCE (with b=1).
REQ-033 The target implementation size SHALL be 120-400 RTL lines in total.

Verification
REQ-034 A bench SHALL cover: start with ciphertext=2790 -> done at cycle +26, plaintext=65 (0x41), range_err=0.
REQ-035 A bench SHALL cover: ciphertext=0 -> plaintext=0; ciphertext=1 -> plaintext=1; ciphertext=3234 -> plaintext=1 (reduced); all with range_err=0.
REQ-036 A bench SHALL cover: all m in 0..255, encrypt with m^17 mod 3233, feed back-to-back with start in each done cycle -> plaintext=m every time, no idle gaps.
REQ-037 A bench SHALL cover: start re-pulsed with ciphertext=5 at cycle +10 of a 2790 job -> single done at +26, plaintext=65.
REQ-038 A bench SHALL cover: reset at cycle +12 of a job -> no done, outputs 0, busy=0 next cycle; new start with 2790 -> 65 at +26.
REQ-039 A bench SHALL cover: ciphertext whose model result exceeds 255 -> range_err=1, plaintext=result[7:0].
